// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer write path. The coordinate width is
// common to the rasteriser and to this writer.
package fb_pkg;

  // Width of the pixel x/y coordinates carried on the pixel stream
  localparam int COORD_W = 10;

  // Default screen geometry and framebuffer address width
  localparam int DEF_H_RES  = 640;
  localparam int DEF_V_RES  = 480;
  localparam int DEF_ADDR_W = 19;

  // Writer FSM: drain pixels, or sweep the whole screen with one color
  typedef enum logic {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } fb_state_t;

endpackage : fb_pkg

// File: rtl/fb_pixel_writer_pix_fifo.sv
// Synchronous first-word-fall-through FIFO used to buffer incoming pixels.
// DEPTH must be a power of two, at least 2. Pushes while full and pops while
// empty are ignored.
module pix_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 28
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] wr_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset empties the FIFO
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples the pre-edge values and simulation matches the flops.
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; the pointers alone
    // define which entries are valid, and a reset here would cost a reset net
    // per bit for no functional gain.
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule : pix_fifo

// File: rtl/fb_pixel_writer.sv
// Framebuffer-side consumer of the rasteriser pixel stream. Buffers pixels,
// drops off-screen points, converts the rest to linear addresses and issues
// one memory write per pixel. Also performs a full-screen clear on request.
module fb_pixel_writer
  import fb_pkg::*;
#(
  parameter int H_RES      = DEF_H_RES,
  parameter int V_RES      = DEF_V_RES,
  parameter int COLOR_W    = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = DEF_ADDR_W
) (
  input  logic               clk,
  input  logic               reset_n,
  // Pixel stream
  input  logic               pix_valid,
  output logic               pix_ready,
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  input  logic [COLOR_W-1:0] pix_color,
  // Clear command
  input  logic               clear_req,
  input  logic [COLOR_W-1:0] clear_color,
  output logic               busy,
  // Framebuffer write port
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [COLOR_W-1:0] mem_wdata,
  input  logic               mem_ack,
  // Statistics
  output logic [15:0]        clipped_cnt
);

  localparam int FIFO_W = 2 * COORD_W + COLOR_W;
  localparam int CW1    = COORD_W + 1;

  // Clip limits one bit wider than a coordinate so any H_RES/V_RES fits
  localparam logic [CW1-1:0]    H_LIM     = CW1'(H_RES);
  localparam logic [CW1-1:0]    V_LIM     = CW1'(V_RES);
  localparam logic [ADDR_W-1:0] H_RES_A   = ADDR_W'(H_RES);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

  // FIFO interface
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FIFO_W-1:0] fifo_head;

  // Decoded FIFO head
  logic [COORD_W-1:0] head_x;
  logic [COORD_W-1:0] head_y;
  logic [COLOR_W-1:0] head_color;
  logic               head_clip;
  logic [ADDR_W-1:0]  head_addr;

  // Control state
  fb_state_t          state;
  logic               clear_pending;
  logic [COLOR_W-1:0] clear_color_q;
  logic               out_free;

  // Output stage registers
  logic               out_we;
  logic [ADDR_W-1:0]  out_addr;
  logic [COLOR_W-1:0] out_data;
  logic [15:0]        clip_q;

  // Ready depends only on registered state, so it never combinationally
  // follows pix_valid
  assign pix_ready = !fifo_full && !clear_pending && (state == RUN);
  assign fifo_push = pix_valid && pix_ready;

  pix_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (FIFO_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .wr_data ({pix_x, pix_y, pix_color}),
    .pop     (fifo_pop),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (fifo_head)
  );

  assign head_x     = fifo_head[FIFO_W-1 -: COORD_W];
  assign head_y     = fifo_head[COLOR_W +: COORD_W];
  assign head_color = fifo_head[COLOR_W-1:0];

  // Off-screen test, then linear address for on-screen points
  assign head_clip = ({1'b0, head_x} >= H_LIM) || ({1'b0, head_y} >= V_LIM);
  assign head_addr = ADDR_W'(head_y) * H_RES_A + ADDR_W'(head_x);

  // The output register may take a new value when idle or being acked
  assign out_free = !out_we || mem_ack;

  // Pixels are only consumed while running; a clipped head pops without a write
  assign fifo_pop = (state == RUN) && !fifo_empty && out_free;

  // Writer FSM with registered memory-port outputs and clip counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= RUN;
      clear_pending <= 1'b0;
      clear_color_q <= '0;
      out_we        <= 1'b0;
      out_addr      <= '0;
      out_data      <= '0;
      clip_q        <= '0;
    end else begin
      // Accept a clear only when none is outstanding
      if (clear_req && !clear_pending && (state == RUN)) begin
        clear_pending <= 1'b1;
        clear_color_q <= clear_color;
      end

      case (state)
        RUN: begin
          if (out_free) begin
            if (!fifo_empty) begin
              if (head_clip) begin
                out_we <= 1'b0;
                if (clip_q != 16'hFFFF) clip_q <= clip_q + 16'd1;
              end else begin
                out_we   <= 1'b1;
                out_addr <= head_addr;
                out_data <= head_color;
              end
            end else if (clear_pending) begin
              // Pixels drained: start the sweep at address 0
              out_we   <= 1'b1;
              out_addr <= '0;
              out_data <= clear_color_q;
              state    <= CLEAR;
            end else begin
              out_we <= 1'b0;
            end
          end
        end

        CLEAR: begin
          // The output address register doubles as the sweep counter
          if (out_we && mem_ack) begin
            if (out_addr == LAST_ADDR) begin
              out_we        <= 1'b0;
              clear_pending <= 1'b0;
              state         <= RUN;
            end else begin
              out_addr <= out_addr + 1'b1;
            end
          end
        end

        default: state <= RUN;
      endcase
    end
  end

  assign mem_we      = out_we;
  assign mem_addr    = out_addr;
  assign mem_wdata   = out_data;
  assign clipped_cnt = clip_q;
  assign busy        = !fifo_empty || out_we || clear_pending || (state == CLEAR);

endmodule : fb_pixel_writer

// File: tb/tb_fb_pixel_writer.sv
// Bench for fb_pixel_writer. Two instances share clock and reset: one at the
// default 640x480 geometry, one at 8x4 for full-screen clears. 'sel' routes
// stimulus to one instance and selects whose outputs are observed.
module tb_fb_pixel_writer;

  typedef struct {
    logic [18:0] addr;
    logic [7:0]  data;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        sel;
  logic        pix_valid;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [7:0]  pix_color;
  logic        clear_req;
  logic [7:0]  clear_color;
  logic        mem_ack;

  logic        a_ready, b_ready, a_busy, b_busy, a_we, b_we;
  logic [18:0] a_addr, b_addr;
  logic [7:0]  a_data, b_data;
  logic [15:0] a_clip, b_clip;

  logic        pix_ready, busy, mem_we;
  logic [18:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [15:0] clipped_cnt;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_writes = 0;

  fb_pixel_writer u_dut_a (
    .clk         (clk),
    .reset_n     (reset_n),
    .pix_valid   (pix_valid & ~sel),
    .pix_ready   (a_ready),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_color   (pix_color),
    .clear_req   (clear_req & ~sel),
    .clear_color (clear_color),
    .busy        (a_busy),
    .mem_we      (a_we),
    .mem_addr    (a_addr),
    .mem_wdata   (a_data),
    .mem_ack     (mem_ack & ~sel),
    .clipped_cnt (a_clip)
  );

  fb_pixel_writer #(.H_RES(8), .V_RES(4)) u_dut_b (
    .clk         (clk),
    .reset_n     (reset_n),
    .pix_valid   (pix_valid & sel),
    .pix_ready   (b_ready),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_color   (pix_color),
    .clear_req   (clear_req & sel),
    .clear_color (clear_color),
    .busy        (b_busy),
    .mem_we      (b_we),
    .mem_addr    (b_addr),
    .mem_wdata   (b_data),
    .mem_ack     (mem_ack & sel),
    .clipped_cnt (b_clip)
  );

  assign pix_ready   = sel ? b_ready : a_ready;
  assign busy        = sel ? b_busy  : a_busy;
  assign mem_we      = sel ? b_we    : a_we;
  assign mem_addr    = sel ? b_addr  : a_addr;
  assign mem_wdata   = sel ? b_data  : a_data;
  assign clipped_cnt = sel ? b_clip  : a_clip;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected write for an accepted pixel, using the selected geometry
  task automatic expect_pixel(input int x, input int y, input int c);
    int   h = sel ? 8 : 640;
    int   v = sel ? 4 : 480;
    exp_t e;
    if (x < h && y < v) begin
      e.addr = 19'(y * h + x);
      e.data = 8'(c);
      sb.push_back(e);
    end
  endtask

  task automatic expect_clear(input int c);
    int   n = sel ? 32 : 640 * 480;
    exp_t e;
    for (int i = 0; i < n && i < 64; i++) begin
      e.addr = 19'(i);
      e.data = 8'(c);
      sb.push_back(e);
    end
  endtask

  // Present one pixel and hold it until accepted (bounded)
  task automatic send_pixel(input int x, input int y, input int c);
    int n = 0;
    pix_valid = 1'b1;
    pix_x     = 10'(x);
    pix_y     = 10'(y);
    pix_color = 8'(c);
    while (!pix_ready && n < 200) begin
      tick();
      n++;
    end
    check("send_ready", 32'(pix_ready), 32'd1);
    if (pix_ready) expect_pixel(x, y, c);
    tick();
    pix_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 1000) begin
      tick();
      n++;
    end
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_sb_left"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    sb.delete();
    reset_n = 1'b1;
    tick();
  endtask

  // Scoreboard: a write is accepted at the rising edge following this sample
  always @(negedge clk) begin
    if (reset_n && mem_we && mem_ack) begin
      n_writes++;
      check("write_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("write_addr", 32'(mem_addr), 32'(e.addr));
        check("write_data", 32'(mem_wdata), 32'(e.data));
      end
    end
  end

  initial begin
    int   idx;
    int   w0;
    int   n;
    logic acc;
    logic busy_early_low;
    logic ready_leak;
    logic pulsed;

    sel         = 1'b0;
    pix_valid   = 1'b0;
    pix_x       = '0;
    pix_y       = '0;
    pix_color   = '0;
    clear_req   = 1'b0;
    clear_color = '0;
    mem_ack     = 1'b0;
    reset_n     = 1'b0;

    // Reset values
    tick();
    tick();
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_clipped", 32'(clipped_cnt), 32'd0);
    check("rst_pix_ready", 32'(pix_ready), 32'd1);
    reset_n = 1'b1;
    tick();

    // Single write with one-cycle latency
    mem_ack   = 1'b1;
    pix_valid = 1'b1;
    pix_x     = 10'd5;
    pix_y     = 10'd5;
    pix_color = 8'hAA;
    check("single_ready", 32'(pix_ready), 32'd1);
    expect_pixel(5, 5, 8'hAA);
    tick();
    pix_valid = 1'b0;
    check("single_we_e0", 32'(mem_we), 32'd0);
    tick();
    check("single_we_e1", 32'(mem_we), 32'd1);
    check("single_addr", 32'(mem_addr), 32'd3205);
    check("single_data", 32'(mem_wdata), 32'hAA);
    check("single_busy", 32'(busy), 32'd1);
    tick();
    check("single_we_e2", 32'(mem_we), 32'd0);
    check("single_busy_e2", 32'(busy), 32'd0);
    check("single_sb_left", 32'(sb.size()), 32'd0);

    // Back-pressure: capacity is FIFO plus output stage
    mem_ack = 1'b0;
    idx     = 0;
    repeat (8) begin
      pix_valid = 1'b1;
      pix_x     = 10'(idx);
      pix_y     = 10'd1;
      pix_color = 8'(8'h30 + idx);
      acc       = pix_ready;
      if (acc) expect_pixel(idx, 1, 8'h30 + idx);
      tick();
      if (acc) idx++;
    end
    pix_valid = 1'b0;
    check("bp_accepted", 32'(idx), 32'd5);
    check("bp_ready_low", 32'(pix_ready), 32'd0);
    check("bp_hold_we", 32'(mem_we), 32'd1);
    check("bp_hold_addr", 32'(mem_addr), 32'd640);
    w0      = n_writes;
    mem_ack = 1'b1;
    repeat (5) tick();
    check("bp_burst_writes", 32'(n_writes - w0), 32'd5);
    send_pixel(5, 1, 8'h35);
    send_pixel(6, 1, 8'h36);
    wait_idle("bp");

    // Clipping
    send_pixel(640, 0, 8'h01);
    send_pixel(0, 480, 8'h02);
    send_pixel(639, 479, 8'h03);
    wait_idle("clip");
    check("clip_count", 32'(clipped_cnt), 32'd2);

    // Full clear on the 8x4 instance, block idle
    sel = 1'b1;
    do_reset();
    clear_color = 8'h11;
    clear_req   = 1'b1;
    expect_clear(8'h11);
    tick();
    clear_req = 1'b0;
    check("clr_ready_low", 32'(pix_ready), 32'd0);
    check("clr_busy", 32'(busy), 32'd1);
    tick();
    check("clr_first_we", 32'(mem_we), 32'd1);
    check("clr_first_addr", 32'(mem_addr), 32'd0);
    w0 = n_writes;
    n  = 0;
    busy_early_low = 1'b0;
    while (n_writes < w0 + 32 && n < 200) begin
      if (!busy) busy_early_low = 1'b1;
      tick();
      n++;
    end
    check("clr_count", 32'(n_writes - w0), 32'd32);
    check("clr_busy_held", 32'(busy_early_low), 32'd0);
    check("clr_busy_fall", 32'(busy), 32'd0);
    check("clr_we_fall", 32'(mem_we), 32'd0);
    check("clr_sb_left", 32'(sb.size()), 32'd0);

    // Clear with pixels queued, plus an ignored second request
    mem_ack = 1'b0;
    send_pixel(1, 0, 8'hA1);
    send_pixel(2, 1, 8'hA2);
    send_pixel(3, 2, 8'hA3);
    clear_color = 8'h22;
    clear_req   = 1'b1;
    expect_clear(8'h22);
    tick();
    clear_req = 1'b0;
    check("cq_ready_low", 32'(pix_ready), 32'd0);
    w0         = n_writes;
    mem_ack    = 1'b1;
    n          = 0;
    ready_leak = 1'b0;
    pulsed     = 1'b0;
    while (n_writes < w0 + 35 && n < 200) begin
      if (n_writes - w0 == 13 && !pulsed) begin
        clear_req   = 1'b1;
        clear_color = 8'h33;
        pulsed      = 1'b1;
      end
      if (pix_ready) ready_leak = 1'b1;
      tick();
      clear_req = 1'b0;
      n++;
    end
    check("cq_pulsed", 32'(pulsed), 32'd1);
    check("cq_count", 32'(n_writes - w0), 32'd35);
    check("cq_ready_held_low", 32'(ready_leak), 32'd0);
    check("cq_busy_fall", 32'(busy), 32'd0);
    check("cq_ready_back", 32'(pix_ready), 32'd1);
    repeat (5) tick();
    check("cq_no_extra", 32'(n_writes - w0), 32'd35);

    // Reset in the middle of a clear on the default instance
    sel = 1'b0;
    do_reset();
    mem_ack     = 1'b1;
    clear_color = 8'h77;
    clear_req   = 1'b1;
    expect_clear(8'h77);
    tick();
    clear_req = 1'b0;
    w0 = n_writes;
    n  = 0;
    while (n_writes < w0 + 10 && n < 100) begin
      tick();
      n++;
    end
    check("rmc_writes", 32'(n_writes - w0), 32'd10);
    reset_n = 1'b0;
    #1;
    check("rmc_we", 32'(mem_we), 32'd0);
    check("rmc_busy", 32'(busy), 32'd0);
    check("rmc_ready", 32'(pix_ready), 32'd1);
    sb.delete();
    tick();
    reset_n = 1'b1;
    tick();
    send_pixel(1, 1, 8'h55);
    wait_idle("rmc");
    check("rmc_clipped", 32'(clipped_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_fb_pixel_writer
